az_pipe_stage: RTL and testbench
================================

# az_pipe_stage

Parametrised pipeline stage register for the az_cpu pipeline, successor to the fixed EX/MEM register. It carries one instruction record (PC, result, control, exception code) between two stages, using a valid/ready handshake in both directions. It supports stall, flush and exception injection with a defined priority. An optional two-entry skid buffer gives a registered upstream ready. Every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiates this one block.

## Interface
- PC_W, 30, PC width (word address)
- DATA_W, 32, result/payload width
- CTRL_W, 8, control bits with side effects (dst addr, write enables, ctrl op); forced to CTRL_KILL when the entry is killed
- CTRL_KILL, 'h1, control value for reset/flushed/excepted entries (bit0 = gpr_wen, active-low disable)
- EXP_W, 3, exception code width; code 0 = none
- Ports:
- cpu_clk  in  1  clock
- cpu_rst  in  1  reset; one clock, reset is asynchronous and active-high
- stall  in  1  hold; behaves as out_ready=0
- flush  in  1  discard all held entries and any entry offered this cycle
- in_valid  in  1  upstream record valid
- in_ready  out  1  stage can accept
- in_pc  in  PC_W  record PC
- in_br_flag  in  1  record sits in a branch delay slot
- in_ctrl  in  CTRL_W  control bits
- in_exp  in  EXP_W  exception already raised upstream
- in_data  in  DATA_W  result
- exc_req  in  1  this stage raises an exception on the offered record
- exc_code  in  EXP_W  code for exc_req (for example 4 = miss-align)
- out_valid, out_pc, out_br_flag, out_ctrl, out_exp, out_data  out  matching widths  registered head entry
- out_ready  in  1  downstream accepts

## Operation
- in_fire = in_valid & in_ready & !flush; out_fire = out_valid & out_ready & !stall.
- Capture priority for each accepted record:
  - If in_exp != 0: store the record unchanged. The earliest exception wins and exc_req is ignored.
  - Else if exc_req: store pc and br_flag, ctrl=CTRL_KILL, exp=exc_code, data=0.
  - Else: store the record unchanged.
- Flush has priority over stall and handshake. All entries are invalidated, the held payload is cleared to the reset values, and the state returns to EMPTY.
- State machine (az_pipe_pkg::pipe_st_t): EMPTY, BUSY (head valid), FULL (head + skid valid; exists only with the skid macro).
  - EMPTY: in_fire -> BUSY.
  - BUSY, in_fire & out_fire -> BUSY, head replaced.
  - BUSY, out_fire only -> EMPTY.
  - BUSY, in_fire only -> FULL when skid is compiled in, else not possible.
  - FULL, out_fire -> BUSY, skid moves to head.
  - FULL: in_ready=0.
- out_valid = state != EMPTY. The out_* signals always show the head entry.
- Reset values: out_valid 0, out_pc 0, out_br_flag 0, out_ctrl CTRL_KILL, out_exp 0, out_data 0, state EMPTY. With skid, in_ready is 0 during reset and 1 one cycle after release.
- Reset asserted mid-transfer drops all entries with no partial update.

## Timing
- Latency 1 cycle from in_fire to out_valid. Throughput 1 record per cycle while out_ready=1 and stall=0.
- No combinational path from in_* to out_*.
- Without skid, in_ready = !out_valid | (out_ready & !stall), which is combinational from out_ready and stall.
- With skid, in_ready = (state != FULL) and comes from a flop, so there is no path from out_ready or stall.
- An entry on out_* holds stable while out_valid=1 and out_fire=0. It changes only on flush or reset.

## Configuration
- AZ_PIPE_SKID_EN defined:
  - Adds the skid entry and the FULL state.
  - in_ready is registered.
  - Zero bubbles after a stall releases.
- AZ_PIPE_SKID_EN undefined:
  - Single entry only.
  - in_ready is combinational as above.
  - Behaviour matches the legacy stage register.

## Structure
- Shared package az_pipe_pkg holds:
  - pipe_st_t enum.
  - Exception constants EXP_NONE=0 and EXP_MISS_ALIGN=4.
  - The pipe_rec_t packed struct template (pc/br_flag/ctrl/exp/data) used by all stages.
- Sub-module az_pipe_slot: one payload register entry with load/clear enables. It is instantiated once for the head and once more for the skid under the macro.

## Test plan
- Reset: cpu_rst=1 mid-stream -> out_valid=0, out_ctrl='h1, out_exp=0, state EMPTY. With skid, in_ready=1 one cycle after release.
- Streaming: 8 back-to-back records, pc 0..7, out_ready=1 -> out_pc 0..7 appear on consecutive cycles, 1-cycle latency, no drops.
- Exception inject: in_exp=0, exc_req=1, exc_code=4, in_ctrl='hF6, in_data='hDEAD -> out_exp=4, out_ctrl='h1, out_data=0, pc kept. Then in_exp=2 with exc_req=1 -> out_exp=2.
- Stall/backpressure (skid): stall=1 for 3 cycles while sending pc 10,11,12 -> in_ready drops after the 2nd record. On release, out shows 10 then 11 on consecutive cycles, and 12 is accepted without loss.
- Flush over stall: FULL state, stall=1, flush=1, in_valid=1 -> next cycle out_valid=0, EMPTY, and the offered record is not captured.
- Flush versus simultaneous out_fire: out_ready=1, flush=1 -> the head still counts as consumed downstream that cycle, and no new entry is captured.

Source files
------------

// File: rtl/az_pipe_pkg.sv
// az_pipe_pkg: shared types and constants for the az_cpu pipeline stage registers.
package az_pipe_pkg;

    localparam int unsigned PIPE_PC_W   = 30;
    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_CTRL_W = 8;
    localparam int unsigned PIPE_EXP_W  = 3;

    // Control value for empty/killed entries: bit0 is gpr_wen, active-low.
    localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_KILL = 8'h01;

    localparam logic [PIPE_EXP_W-1:0] EXP_NONE       = 3'd0;
    localparam logic [PIPE_EXP_W-1:0] EXP_MISS_ALIGN = 3'd4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_st_t;

    // Instruction record template at the default widths.
    typedef struct packed {
        logic [PIPE_PC_W-1:0]   pc;
        logic                   br_flag;
        logic [PIPE_CTRL_W-1:0] ctrl;
        logic [PIPE_EXP_W-1:0]  exp;
        logic [PIPE_DATA_W-1:0] data;
    } pipe_rec_t;

endpackage

// File: rtl/az_pipe_slot.sv
// az_pipe_slot: one payload register entry with load and clear enables.
module az_pipe_slot #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over load so a flush never lets a record slip in.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            q <= RST_VAL;
        end else if (clear) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/az_pipe_stage.sv
// az_pipe_stage: valid/ready pipeline stage register with stall, flush and
// exception injection. Define AZ_PIPE_SKID_EN for the two-entry skid variant
// with a registered in_ready.
module az_pipe_stage
    import az_pipe_pkg::*;
#(
    parameter int unsigned        PC_W      = PIPE_PC_W,
    parameter int unsigned        DATA_W    = PIPE_DATA_W,
    parameter int unsigned        CTRL_W    = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0]  CTRL_KILL = CTRL_W'(PIPE_CTRL_KILL),
    parameter int unsigned        EXP_W     = PIPE_EXP_W
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_br_flag,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [DATA_W-1:0] in_data,
    input  logic              exc_req,
    input  logic [EXP_W-1:0]  exc_code,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_br_flag,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [EXP_W-1:0]  out_exp,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int unsigned      REC_W   = PC_W + 1 + CTRL_W + EXP_W + DATA_W;
    localparam logic [REC_W-1:0] REC_RST = {PC_W'(0), 1'b0, CTRL_KILL, EXP_W'(0), DATA_W'(0)};

    pipe_st_t         state;
    pipe_st_t         next_state;
    logic             in_fire;
    logic             out_fire;
    logic [REC_W-1:0] cap_rec;
    logic [REC_W-1:0] head_d;
    logic [REC_W-1:0] head_q;
    logic             head_load;
`ifdef AZ_PIPE_SKID_EN
    logic             skid_load;
    logic [REC_W-1:0] skid_q;
`endif

    assign out_fire = out_valid & out_ready & ~stall;
    assign in_fire  = in_valid & in_ready & ~flush;

    // Record to store: an upstream exception wins, else a local one kills the payload.
    always_comb begin
        cap_rec = {in_pc, in_br_flag, in_ctrl, in_exp, in_data};
        if ((in_exp == EXP_W'(EXP_NONE)) && exc_req) begin
            cap_rec = {in_pc, in_br_flag, CTRL_KILL, exc_code, DATA_W'(0)};
        end
    end

    // Next state and slot load enables; flush overrides everything.
    always_comb begin
        next_state = state;
        head_load  = 1'b0;
        head_d     = cap_rec;
`ifdef AZ_PIPE_SKID_EN
        skid_load  = 1'b0;
`endif
        case (state)
            ST_EMPTY: begin
                head_load = in_fire;
                if (in_fire) next_state = ST_BUSY;
            end
            ST_BUSY: begin
                head_load = in_fire & out_fire;
`ifdef AZ_PIPE_SKID_EN
                skid_load = in_fire & ~out_fire;
`endif
                if (out_fire && !in_fire) next_state = ST_EMPTY;
`ifdef AZ_PIPE_SKID_EN
                else if (in_fire && !out_fire) next_state = ST_FULL;
`endif
            end
`ifdef AZ_PIPE_SKID_EN
            ST_FULL: begin
                head_load = out_fire;
                head_d    = skid_q;
                if (out_fire) next_state = ST_BUSY;
            end
`endif
            default: next_state = ST_EMPTY;
        endcase
        if (flush) next_state = ST_EMPTY;
    end

    // State register.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) state <= ST_EMPTY;
        else         state <= next_state;
    end

    // Registered head-valid flag.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) out_valid <= 1'b0;
        else         out_valid <= (next_state != ST_EMPTY);
    end

`ifdef AZ_PIPE_SKID_EN
    // Registered ready: low while both entries are occupied, and held low in reset.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) in_ready <= 1'b0;
        else         in_ready <= (next_state != ST_FULL);
    end

    az_pipe_slot #(.W(REC_W), .RST_VAL(REC_RST)) u_skid (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .load    (skid_load),
        .clear   (flush),
        .d       (cap_rec),
        .q       (skid_q)
    );
`else
    assign in_ready = ~out_valid | (out_ready & ~stall);
`endif

    az_pipe_slot #(.W(REC_W), .RST_VAL(REC_RST)) u_head (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .load    (head_load),
        .clear   (flush),
        .d       (head_d),
        .q       (head_q)
    );

    assign {out_pc, out_br_flag, out_ctrl, out_exp, out_data} = head_q;

endmodule

// File: tb/tb_az_pipe_stage.sv
// tb_az_pipe_stage: directed + randomized bench with a queue-based reference model.
module tb_az_pipe_stage;
    import az_pipe_pkg::*;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
    logic [29:0] in_pc = '0;
    logic        in_br_flag = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [2:0]  in_exp = '0;
    logic [31:0] in_data = '0;
    logic        exc_req = 1'b0;
    logic [2:0]  exc_code = '0;
    logic        out_valid, out_br_flag;
    logic [29:0] out_pc;
    logic [7:0]  out_ctrl;
    logic [2:0]  out_exp;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;

    always #5 cpu_clk = ~cpu_clk;

    az_pipe_stage dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_br_flag(in_br_flag), .in_ctrl(in_ctrl), .in_exp(in_exp),
        .in_data(in_data), .exc_req(exc_req), .exc_code(exc_code),
        .out_valid(out_valid), .out_pc(out_pc), .out_br_flag(out_br_flag),
        .out_ctrl(out_ctrl), .out_exp(out_exp), .out_data(out_data),
        .out_ready(out_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO of held records, ready-armed flag, and "payload is at reset values".
    pipe_rec_t mq[$];
    bit        armed = 1'b0;
    bit        clean = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_rdy();
`ifdef AZ_PIPE_SKID_EN
        return armed && (mq.size() < 2);
`else
        return (mq.size() == 0) || (out_ready && !stall);
`endif
    endfunction

    function automatic pipe_rec_t cap_model();
        pipe_rec_t r;
        r.pc = in_pc; r.br_flag = in_br_flag; r.ctrl = in_ctrl; r.exp = in_exp; r.data = in_data;
        if (in_exp == 3'd0 && exc_req) begin
            r.ctrl = 8'h01; r.exp = exc_code; r.data = 32'd0;
        end
        return r;
    endfunction

    // Model update at each active edge.
    always @(posedge cpu_clk) begin : model_upd
        logic ofire, ifire;
        pipe_rec_t r;
        if (cpu_rst) begin
            mq.delete(); armed = 1'b0; clean = 1'b1;
        end else begin
            ofire = (mq.size() > 0) && out_ready && !stall;
            ifire = in_valid && exp_rdy() && !flush;
            r = cap_model();
            if (flush) begin
                mq.delete(); clean = 1'b1;
            end else begin
                if (ofire) void'(mq.pop_front());
                if (ifire) begin mq.push_back(r); clean = 1'b0; end
            end
            armed = 1'b1;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge cpu_clk) begin
        chk("out_valid", out_valid, mq.size() > 0);
        chk("in_ready", in_ready, exp_rdy());
        if (mq.size() > 0)
            chk("head", {out_pc, out_br_flag, out_ctrl, out_exp, out_data}, mq[0]);
        else if (clean)
            chk("reset_payload", {out_pc, out_br_flag, out_ctrl, out_exp, out_data},
                {30'd0, 1'b0, 8'h01, 3'd0, 32'd0});
    end

    task automatic tick();
        @(negedge cpu_clk); #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; stall = 0; exc_req = 0; in_exp = 0;
    endtask

    initial begin
        int got_pc[$];
        int got_cyc[$];
        int k;
        logic rdy1, rdy2, acc;

        repeat (3) tick();
`ifdef AZ_PIPE_SKID_EN
        chk("rst_in_ready_low", in_ready, 1'b0);
`endif
        cpu_rst = 0;
        tick();
        chk("rel_in_ready", in_ready, 1'b1);
        chk("rel_out_valid", out_valid, 1'b0);
        chk("rel_out_ctrl", out_ctrl, 8'h01);

        // Streaming: 8 back-to-back records.
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_pc = 30'(i); in_data = $urandom; in_ctrl = 8'($urandom);
            in_br_flag = 1'($urandom);
            tick();
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_pc", out_pc, 30'(i));
        end

        // Reset mid-stream: asynchronous clear.
        cpu_rst = 1; #1;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_ctrl", out_ctrl, 8'h01);
        chk("rst_mid_exp", out_exp, 3'd0);
        tick(); idle(); tick();
        cpu_rst = 0;
        tick();
        chk("rst_rel_ready", in_ready, 1'b1);

        // Exception injection and earliest-exception-wins.
        out_ready = 0;
        in_valid = 1; in_pc = 30'h123; in_exp = 0; exc_req = 1; exc_code = 3'd4;
        in_ctrl = 8'hF6; in_data = 32'hDEAD;
        tick();
        in_valid = 0; exc_req = 0;
        chk("exc_exp", out_exp, 3'd4);
        chk("exc_ctrl", out_ctrl, 8'h01);
        chk("exc_data", out_data, 32'd0);
        chk("exc_pc", out_pc, 30'h123);
        out_ready = 1;
        in_valid = 1; in_pc = 30'h124; in_exp = 3'd2; exc_req = 1; exc_code = 3'd4;
        in_ctrl = 8'h55; in_data = 32'hBEEF;
        tick();
        chk("early_exp", out_exp, 3'd2);
        chk("early_ctrl", out_ctrl, 8'h55);
        chk("early_data", out_data, 32'hBEEF);
        idle(); tick(); tick();

        // Stall / backpressure: offer 10,11,12 with stall held for 3 cycles.
        k = 0; rdy1 = 1'bx; rdy2 = 1'bx;
        out_ready = 1; in_exp = 0; exc_req = 0;
        for (int c = 0; c < 20 && got_pc.size() < 3; c++) begin
            stall = (c < 3); in_valid = (k < 3); in_pc = 30'(10 + k);
            #1;
            acc = in_valid & in_ready;
            if (out_valid && out_ready && !stall) begin
                got_pc.push_back(int'(out_pc)); got_cyc.push_back(c);
            end
            if (c == 1) rdy1 = in_ready;
            if (c == 2) rdy2 = in_ready;
            tick();
            if (acc) k++;
        end
        idle();
        chk("stall_count", got_pc.size(), 3);
        if (got_pc.size() == 3) begin
            chk("stall_out0", got_pc[0], 10);
            chk("stall_out1", got_pc[1], 11);
            chk("stall_out2", got_pc[2], 12);
            chk("stall_consec", got_cyc[1], got_cyc[0] + 1);
        end
        chk("stall_rdy_c2", rdy2, 1'b0);
`ifdef AZ_PIPE_SKID_EN
        chk("stall_rdy_c1", rdy1, 1'b1);
`else
        chk("stall_rdy_c1", rdy1, 1'b0);
`endif
        tick(); tick();

        // Flush over stall (FULL with the skid entry).
        stall = 1; out_ready = 1; in_valid = 1; in_pc = 30'd20;
        tick();
        in_pc = 30'd21;
        tick();
`ifdef AZ_PIPE_SKID_EN
        chk("full_in_ready", in_ready, 1'b0);
`endif
        flush = 1; in_pc = 30'd99;
        tick();
        idle();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ctrl", out_ctrl, 8'h01);
        chk("flush_pc", out_pc, 30'd0);
        tick();
        chk("flush_stays_empty", out_valid, 1'b0);

        // Flush together with a downstream consume.
        out_ready = 0; in_valid = 1; in_pc = 30'd30;
        tick();
        out_ready = 1; flush = 1; in_pc = 30'd31;
        #1;
        chk("flush_fire_consumed", out_valid & out_ready & ~stall, 1'b1);
        chk("flush_fire_pc", out_pc, 30'd30);
        tick();
        idle();
        chk("flush_fire_empty", out_valid, 1'b0);
        chk("flush_fire_nocap", out_pc, 30'd0);

        // Randomized traffic, including occasional mid-stream reset.
        for (int c = 0; c < 3000; c++) begin
            cpu_rst    = ($urandom_range(0, 299) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_pc      = 30'($urandom);
            in_br_flag = 1'($urandom);
            in_ctrl    = 8'($urandom);
            in_data    = $urandom;
            in_exp     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            exc_req    = ($urandom_range(0, 5) == 0);
            exc_code   = 3'($urandom_range(1, 7));
            out_ready  = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 9) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            tick();
        end
        cpu_rst = 0; idle(); out_ready = 1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
